uart_rx: RTL

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx_if.sv | 22 ++
 rtl/uart_rx.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/uart_rx_if.sv
// uart_rx_if: serial line input and received-word/status outputs of uart_rx.
// master = line driver / consumer side, slave = the receiver.
interface uart_rx_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic                 rxd;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 frame_err;
  logic                 parity_err;
  logic                 rx_busy;

  modport master (
    output rxd,
    input  rx_data, rx_valid, frame_err, parity_err, rx_busy
  );

  modport slave (
    input  rxd,
    output rx_data, rx_valid, frame_err, parity_err, rx_busy
  );
endinterface

// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver, idle-high line, LSB first, one stop bit.
// Define UART_RX_PARITY_EN to add an even-parity bit after the data bits;
// without it parity_err is tied low.
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned DATA_BITS    = 8
) (
  input logic      clk,
  input logic      reset,
  uart_rx_if.slave bus
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam int unsigned BW = $clog2(DATA_BITS);
  // The counter is cleared one cycle after the low is first seen, so deciding
  // at HALF_LAST puts the start-bit check CLKS_PER_BIT/2 cycles into the low.
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_END   = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t               state;
  logic [1:0]           sync;
  logic                 rxd_s;
  logic                 rxd_prev;
  logic [CW-1:0]        cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q;
  logic                 ferr_q;
  logic                 busy_q;
`ifdef UART_RX_PARITY_EN
  logic                 par_q;
  logic                 perr_q;
  logic                 par_bad;

  assign par_bad = ^{shreg, par_q};
`endif

  assign rxd_s = sync[1];

  // Two-flop synchronizer plus a delayed copy for falling-edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync     <= 2'b11;
      rxd_prev <= 1'b1;
    end else begin
      sync     <= {sync[0], bus.rxd};
      rxd_prev <= rxd_s;
    end
  end

  // Receive FSM: bit timing, shifting, frame checks and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      busy_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q   <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q  <= 1'b0;
`endif
      unique case (state)
        IDLE: begin
          if (rxd_prev && !rxd_s) begin
            state  <= START;
            cnt    <= '0;
            busy_q <= 1'b1;
          end
        end
        START: begin
          if (cnt == HALF_LAST) begin
            cnt <= '0;
            if (!rxd_s) begin
              state   <= DATA;
              bit_cnt <= '0;
            end else begin
              state  <= IDLE;
              busy_q <= 1'b0;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DATA: begin
          if (cnt == BIT_END) begin
            cnt   <= '0;
            shreg <= {rxd_s, shreg[DATA_BITS-1:1]};
            if (bit_cnt == LAST_BIT) begin
              bit_cnt <= '0;
`ifdef UART_RX_PARITY_EN
              state   <= PARITY;
`else
              state   <= STOP;
`endif
            end else begin
              bit_cnt <= bit_cnt + BW'(1);
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (cnt == BIT_END) begin
            cnt   <= '0;
            par_q <= rxd_s;
            state <= STOP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
`endif
        STOP: begin
          if (cnt == BIT_END) begin
            cnt    <= '0;
            state  <= IDLE;
            busy_q <= 1'b0;
            data_q <= shreg;
`ifdef UART_RX_PARITY_EN
            valid_q <= rxd_s & ~par_bad;
            ferr_q  <= ~rxd_s;
            perr_q  <= par_bad;
`else
            valid_q <= rxd_s;
            ferr_q  <= ~rxd_s;
`endif
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rx_data   = data_q;
  assign bus.rx_valid  = valid_q;
  assign bus.frame_err = ferr_q;
  assign bus.rx_busy   = busy_q;
`ifdef UART_RX_PARITY_EN
  assign bus.parity_err = perr_q;
`else
  assign bus.parity_err = 1'b0;
`endif

endmodule
